knn_dist_sched: RTL and testbench

//  Initiator/collector that drives the Manhattan distance unit's valid/ready-in, valid/yumi-out protocol.

---
 rtl/knn_dist_sched_if.sv | 25 ++
 rtl/knn_dist_sched.sv | 155 +++++++++++++++
 tb/tb_knn_dist_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_dist_sched_if.sv
// Bus between the k-NN scheduler (master) and the Manhattan distance unit (slave):
// a valid/ready request channel carrying two points, and a valid/yumi result channel.
interface knn_dist_sched_if #(
   parameter int WIDTH = 4
);
   logic                 dm_valid_o;
   logic                 dm_ready_i;
   logic [WIDTH-1:0]     dm_x1_o;
   logic [WIDTH-1:0]     dm_y1_o;
   logic [WIDTH-1:0]     dm_x2_o;
   logic [WIDTH-1:0]     dm_y2_o;
   logic                 dm_valid_i;
   logic [2*WIDTH-1:0]   dm_dist_i;
   logic                 dm_yumi_o;

   modport master (
      output dm_valid_o, dm_x1_o, dm_y1_o, dm_x2_o, dm_y2_o, dm_yumi_o,
      input  dm_ready_i, dm_valid_i, dm_dist_i
   );

   modport slave (
      input  dm_valid_o, dm_x1_o, dm_y1_o, dm_x2_o, dm_y2_o, dm_yumi_o,
      output dm_ready_i, dm_valid_i, dm_dist_i
   );
endinterface

// File: rtl/knn_dist_sched.sv
// k-NN distance scheduler: stores N_PTS labelled points, streams each one with a latched
// query to the distance unit, and keeps a sorted list of the K nearest (distance, label).
module knn_dist_sched #(
   parameter int WIDTH = 4,
   parameter int N_PTS = 8,
   parameter int K     = 3,
   parameter int LBL_W = 2,
   localparam int AW   = (N_PTS > 1) ? $clog2(N_PTS) : 1,
   localparam int DW   = 2 * WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 pt_we_i,
   input  logic [AW-1:0]        pt_addr_i,
   input  logic [WIDTH-1:0]     pt_x_i,
   input  logic [WIDTH-1:0]     pt_y_i,
   input  logic [LBL_W-1:0]     pt_lbl_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     qx_i,
   input  logic [WIDTH-1:0]     qy_i,
   knn_dist_sched_if.master     dm,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [K*DW-1:0]      knn_dist_o,
   output logic [K*LBL_W-1:0]   knn_lbl_o
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [WIDTH-1:0]  qx_q, qx_d, qy_q, qy_d;
   logic [DW-1:0]     dist_q [K];
   logic [DW-1:0]     dist_d [K];
   logic [LBL_W-1:0]  lbl_q  [K];
   logic [LBL_W-1:0]  lbl_d  [K];

   logic [WIDTH-1:0]  mem_x_q   [N_PTS];
   logic [WIDTH-1:0]  mem_y_q   [N_PTS];
   logic [LBL_W-1:0]  mem_lbl_q [N_PTS];
   logic              mem_we;
   logic [31:0]       addr_ext;

   logic [K-1:0]      lt;
   logic [DW-1:0]     ins_dist [K];
   logic [LBL_W-1:0]  ins_lbl  [K];
   logic [LBL_W-1:0]  cur_lbl;

   // Writes are only honoured while idle so a running search sees a frozen point set.
   assign addr_ext = 32'(pt_addr_i);
   assign mem_we   = pt_we_i && (state_q == S_IDLE) && (addr_ext < 32'(N_PTS));

   // Point memory write port (contents survive reset).
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_x_q[pt_addr_i]   <= pt_x_i;
         mem_y_q[pt_addr_i]   <= pt_y_i;
         mem_lbl_q[pt_addr_i] <= pt_lbl_i;
      end
   end

   assign cur_lbl    = mem_lbl_q[idx_q];
   assign dm.dm_x1_o = qx_q;
   assign dm.dm_y1_o = qy_q;
   assign dm.dm_x2_o = mem_x_q[idx_q];
   assign dm.dm_y2_o = mem_y_q[idx_q];
   assign busy_o     = (state_q != S_IDLE);

   // Sorted-insert network: the list is ascending, so lt[] is a thermometer code.
   // Slot j takes the new entry at the first strict-less slot and the shifted-down
   // neighbour above it; equal distances never displace, keeping earlier points lower.
   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_ins
         assign lt[gi] = (dm.dm_dist_i < dist_q[gi]);
         if (gi == 0) begin : g_first
            assign ins_dist[gi] = lt[gi] ? dm.dm_dist_i : dist_q[gi];
            assign ins_lbl[gi]  = lt[gi] ? cur_lbl      : lbl_q[gi];
         end else begin : g_rest
            assign ins_dist[gi] = lt[gi-1] ? dist_q[gi-1] : (lt[gi] ? dm.dm_dist_i : dist_q[gi]);
            assign ins_lbl[gi]  = lt[gi-1] ? lbl_q[gi-1]  : (lt[gi] ? cur_lbl      : lbl_q[gi]);
         end
         assign knn_dist_o[gi*DW +: DW]       = dist_q[gi];
         assign knn_lbl_o[gi*LBL_W +: LBL_W]  = lbl_q[gi];
      end
   endgenerate

   // Next-state, handshake outputs and list update.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      qx_d          = qx_q;
      qy_d          = qy_q;
      dist_d        = dist_q;
      lbl_d         = lbl_q;
      dm.dm_valid_o = 1'b0;
      dm.dm_yumi_o  = 1'b0;
      done_o        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               qx_d  = qx_i;
               qy_d  = qy_i;
               idx_d = '0;
               for (int j = 0; j < K; j++) begin
                  dist_d[j] = '1;
                  lbl_d[j]  = '0;
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            dm.dm_valid_o = 1'b1;
            if (dm.dm_ready_i) state_d = S_COLLECT;
         end
         S_COLLECT: begin
            dm.dm_yumi_o = dm.dm_valid_i;
            if (dm.dm_valid_i) begin
               dist_d = ins_dist;
               lbl_d  = ins_lbl;
               if (idx_q == AW'(N_PTS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, query and result registers; reset abandons any search in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         qx_q    <= '0;
         qy_q    <= '0;
         for (int j = 0; j < K; j++) begin
            dist_q[j] <= '1;
            lbl_q[j]  <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         qx_q    <= qx_d;
         qy_q    <= qy_d;
         dist_q  <= dist_d;
         lbl_q   <= lbl_d;
      end
   end
endmodule

// File: tb/tb_knn_dist_sched.sv
// Bench for knn_dist_sched: table of directed searches, corner-case sequences and
// randomized searches checked against a sort-based k-nearest reference model.
module tb_knn_dist_sched;
   localparam int W  = 4;
   localparam int N  = 8;
   localparam int K  = 3;
   localparam int LW = 2;
   localparam int DW = 2 * W;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              pt_we_i;
   logic [2:0]        pt_addr_i;
   logic [W-1:0]      pt_x_i, pt_y_i;
   logic [LW-1:0]     pt_lbl_i;
   logic              start_i;
   logic [W-1:0]      qx_i, qy_i;
   logic              busy_o, done_o;
   logic [K*DW-1:0]   knn_dist_o;
   logic [K*LW-1:0]   knn_lbl_o;

   knn_dist_sched_if #(.WIDTH(W)) dm ();

   knn_dist_sched #(.WIDTH(W), .N_PTS(N), .K(K), .LBL_W(LW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pt_we_i(pt_we_i), .pt_addr_i(pt_addr_i),
      .pt_x_i(pt_x_i), .pt_y_i(pt_y_i), .pt_lbl_i(pt_lbl_i), .start_i(start_i),
      .qx_i(qx_i), .qy_i(qy_i), .dm(dm), .busy_o(busy_o), .done_o(done_o),
      .knn_dist_o(knn_dist_o), .knn_lbl_o(knn_lbl_o)
   );

   always #5 clk_i = ~clk_i;

   int nvec = 0;
   int nmis = 0;

   // Responder configuration: ready after rdly cycles of valid, result vmin..vmax cycles
   // after the first collect cycle.
   int rdly = 0;
   int vmin = 2;
   int vmax = 2;

   // Reference copy of point memory.
   int ref_x [N];
   int ref_y [N];
   int ref_l [N];

   typedef struct {
      logic [W-1:0]    qx;
      logic [W-1:0]    qy;
      logic [K*DW-1:0] edist;
      logic [K*LW-1:0] elbl;
      int              ecyc;
   } vec_t;
   vec_t tbl [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // k nearest by repeated minimum selection; lowest index wins ties.
   function automatic void model(input int qx, input int qy,
                                 output logic [K*DW-1:0] ed, output logic [K*LW-1:0] el);
      int d [N];
      bit used [N];
      int best;
      for (int i = 0; i < N; i++) begin
         d[i] = ((qx > ref_x[i]) ? qx - ref_x[i] : ref_x[i] - qx) +
                ((qy > ref_y[i]) ? qy - ref_y[i] : ref_y[i] - qy);
         used[i] = 1'b0;
      end
      ed = '1;
      el = '0;
      for (int s = 0; s < K; s++) begin
         best = -1;
         for (int i = 0; i < N; i++)
            if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
         used[best] = 1'b1;
         ed[s*DW +: DW] = DW'(d[best]);
         el[s*LW +: LW] = LW'(ref_l[best]);
      end
   endfunction

   // Distance-unit responder with protocol checks on the request side.
   initial begin
      int phase, rcnt, wcnt, dx, dy;
      logic [4*W-1:0] snap;
      phase = 0; rcnt = 0; wcnt = 0; snap = '0;
      dm.dm_ready_i = 1'b0; dm.dm_valid_i = 1'b0; dm.dm_dist_i = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            phase = 0; rcnt = 0;
            dm.dm_ready_i = 1'b0; dm.dm_valid_i = 1'b0;
         end else begin
            if (phase == 3) begin
               dm.dm_valid_i = 1'b0; phase = 0; rcnt = 0;
            end else if (phase == 2) begin
               chk("one_outstanding", 64'(dm.dm_valid_o), 64'd0);
               if (wcnt > 0) wcnt--;
               if (wcnt == 0) begin dm.dm_valid_i = 1'b1; phase = 3; end
            end else if (phase == 1) begin
               dm.dm_ready_i = 1'b0;
               chk("one_outstanding", 64'(dm.dm_valid_o), 64'd0);
               wcnt = $urandom_range(vmax, vmin);
               phase = 2;
               if (wcnt == 0) begin dm.dm_valid_i = 1'b1; phase = 3; end
            end
            if (phase == 0 && dm.dm_valid_o) begin
               if (rcnt == 0) snap = {dm.dm_x1_o, dm.dm_y1_o, dm.dm_x2_o, dm.dm_y2_o};
               else chk("req_stable", 64'({dm.dm_x1_o, dm.dm_y1_o, dm.dm_x2_o, dm.dm_y2_o}), 64'(snap));
               if (rcnt >= rdly) begin
                  dx = (dm.dm_x1_o > dm.dm_x2_o) ? int'(dm.dm_x1_o - dm.dm_x2_o) : int'(dm.dm_x2_o - dm.dm_x1_o);
                  dy = (dm.dm_y1_o > dm.dm_y2_o) ? int'(dm.dm_y1_o - dm.dm_y2_o) : int'(dm.dm_y2_o - dm.dm_y1_o);
                  dm.dm_dist_i  = DW'(dx + dy);
                  dm.dm_ready_i = 1'b1;
                  phase = 1;
               end else begin
                  rcnt++;
               end
            end
         end
      end
   end

   // Called at a negedge; the write lands at the next rising edge.
   task automatic write_pt(input int a, input int x, input int y, input int l);
      pt_we_i = 1'b1; pt_addr_i = 3'(a); pt_x_i = W'(x); pt_y_i = W'(y); pt_lbl_i = LW'(l);
      ref_x[a] = x; ref_y[a] = y; ref_l[a] = l;
      @(negedge clk_i);
      pt_we_i = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge where done_o is seen (cyc = its cycle).
   task automatic do_search(input int qx, input int qy, input int disturb_at, output int cyc);
      start_i = 1'b1; qx_i = W'(qx); qy_i = W'(qy);
      @(negedge clk_i);
      start_i = 1'b0; pt_we_i = 1'b0;
      cyc = 1;
      chk("busy_after_start", 64'(busy_o), 64'd1);
      chk("list_sentinel_on_start", 64'(knn_dist_o), 64'(24'hFFFFFF));
      while (!done_o && cyc < 2000) begin
         if (cyc == disturb_at) begin
            start_i = 1'b1; qx_i = 4'd9; qy_i = 4'd9;
            pt_we_i = 1'b1; pt_addr_i = 3'd7; pt_x_i = 4'd3; pt_y_i = 4'd0; pt_lbl_i = 2'd1;
         end else begin
            start_i = 1'b0; pt_we_i = 1'b0;
         end
         @(negedge clk_i);
         cyc++;
      end
      start_i = 1'b0; pt_we_i = 1'b0;
      chk("done_seen", 64'(done_o), 64'd1);
      $display("search q=(%0d,%0d) done_cycle=%0d dist=%h lbl=%h", qx, qy, cyc, knn_dist_o, knn_lbl_o);
   endtask

   // Check results at done, then one cycle later: pulse over, idle, results held.
   task automatic check_done(input string tag, input logic [K*DW-1:0] ed, input logic [K*LW-1:0] el);
      chk({tag, "_dist"}, 64'(knn_dist_o), 64'(ed));
      chk({tag, "_lbl"}, 64'(knn_lbl_o), 64'(el));
      @(negedge clk_i);
      chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
      chk({tag, "_idle"}, 64'(busy_o), 64'd0);
      chk({tag, "_held"}, 64'({knn_dist_o, knn_lbl_o}), 64'({ed, el}));
   endtask

   initial begin
      int cyc, nacc, guard;
      logic [K*DW-1:0] ed;
      logic [K*LW-1:0] el;

      tbl[0] = '{4'd3,  4'd0,  24'h010100, 6'b00_10_11, 33};
      tbl[1] = '{4'd7,  4'd0,  24'h020100, 6'b01_10_11, 33};
      tbl[2] = '{4'd0,  4'd0,  24'h020100, 6'b10_01_00, 33};
      tbl[3] = '{4'd15, 4'd15, 24'h191817, 6'b01_10_11, 33};

      rst_ni = 1'b0; pt_we_i = 1'b0; pt_addr_i = '0; pt_x_i = '0; pt_y_i = '0;
      pt_lbl_i = '0; start_i = 1'b0; qx_i = '0; qy_i = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_valid", 64'(dm.dm_valid_o), 64'd0);
      chk("rst_yumi", 64'(dm.dm_yumi_o), 64'd0);
      chk("rst_dist", 64'(knn_dist_o), 64'(24'hFFFFFF));
      chk("rst_lbl", 64'(knn_lbl_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Points (i,0) labelled i%4.
      for (int i = 0; i < N; i++) write_pt(i, i, 0, i % 4);

      // Directed table, each start issued in the cycle after the previous done.
      for (int v = 0; v < 4; v++) begin
         do_search(int'(tbl[v].qx), int'(tbl[v].qy), -1, cyc);
         chk("done_cycle", 64'(cyc), 64'(tbl[v].ecyc));
         check_done("table", tbl[v].edist, tbl[v].elbl);
      end

      // Backpressure: ready held off 5 cycles, random result delay.
      rdly = 5; vmin = 0; vmax = 4;
      do_search(3, 0, -1, cyc);
      check_done("backpressure", tbl[0].edist, tbl[0].elbl);
      rdly = 0; vmin = 2; vmax = 2;

      // start_i and pt_we_i pulsed mid-search are ignored.
      do_search(3, 0, 10, cyc);
      check_done("ignored_ctrl", tbl[0].edist, tbl[0].elbl);
      do_search(3, 0, -1, cyc);
      check_done("mem_unchanged", tbl[0].edist, tbl[0].elbl);

      // All points equal: ties resolved by index.
      for (int i = 0; i < N; i++) write_pt(i, 7, 7, (i + 1) % 4);
      do_search(0, 0, -1, cyc);
      check_done("all_equal", 24'h0E0E0E, 6'b11_10_01);

      // Reset after three points have been collected.
      start_i = 1'b1; qx_i = 4'd3; qy_i = 4'd0;
      @(negedge clk_i);
      start_i = 1'b0;
      nacc = 0; guard = 0;
      while (nacc < 3 && guard < 500) begin
         @(negedge clk_i); #1;
         if (dm.dm_yumi_o) nacc++;
         guard++;
      end
      chk("reset_wait_points", 64'(nacc), 64'd3);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_valid", 64'(dm.dm_valid_o), 64'd0);
      chk("midrst_dist", 64'(knn_dist_o), 64'(24'hFFFFFF));
      chk("midrst_lbl", 64'(knn_lbl_o), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         chk("midrst_no_done", 64'(done_o), 64'd0);
      end
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("postrst_no_done", 64'(done_o | busy_o), 64'd0);
      end

      // Randomized searches; the last point write shares its cycle with start_i.
      for (int it = 0; it < 8; it++) begin
         rdly = $urandom_range(3, 0); vmin = 0; vmax = 4;
         for (int i = 0; i < N - 1; i++)
            write_pt(i, $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(3, 0));
         pt_we_i = 1'b1; pt_addr_i = 3'(N - 1);
         ref_x[N-1] = $urandom_range(15, 0); ref_y[N-1] = $urandom_range(15, 0);
         ref_l[N-1] = $urandom_range(3, 0);
         pt_x_i = W'(ref_x[N-1]); pt_y_i = W'(ref_y[N-1]); pt_lbl_i = LW'(ref_l[N-1]);
         qx_i = W'($urandom_range(15, 0)); qy_i = W'($urandom_range(15, 0));
         model(int'(qx_i), int'(qy_i), ed, el);
         do_search(int'(qx_i), int'(qy_i), -1, cyc);
         check_done("random", ed, el);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
